// File: rtl/jt51_timer_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : jt51_timer_bank_if
// Purpose  : Control/status bundle between a host and the jt51 timer bank.
// Revision : 1.0
// ============================================================================
interface jt51_timer_bank_if #(
  parameter int N  = 2,
  parameter int CW = 10
);
  logic            cen;
  logic            zero;
  logic [N*CW-1:0] start_value;
  logic [N-1:0]    load;
  logic [N-1:0]    oneshot;
  logic [N-1:0]    presc_en;
  logic [N-1:0]    clr_flag;
  logic [N-1:0]    irq_en;
  logic [N-1:0]    flag;
  logic [N-1:0]    overflow;
  logic [N-1:0]    running;
  logic            irq_n;

  modport master (
    output cen, zero, start_value, load, oneshot, presc_en, clr_flag, irq_en,
    input  flag, overflow, running, irq_n
  );

  modport slave (
    input  cen, zero, start_value, load, oneshot, presc_en, clr_flag, irq_en,
    output flag, overflow, running, irq_n
  );
endinterface
`default_nettype wire

// File: rtl/jt51_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : jt51_timer_bank
// Purpose  : N independent up-counting timers sharing one tick prescaler.
// Revision : 1.0
// ============================================================================
module jt51_timer_bank #(
  parameter int N  = 2,
  parameter int CW = 10,
  parameter int PW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jt51_timer_bank_if.slave     bus
);

  logic          w_tick;
  logic          w_pwrap;
  logic [PW-1:0] r_presc;
  logic [N-1:0]  w_flag;
  logic [N-1:0]  w_overflow;
  logic [N-1:0]  w_running;

  assign w_tick  = bus.cen & bus.zero;
  assign w_pwrap = w_tick & (&r_presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= r_presc + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [CW-1:0] r_cnt;
      logic          r_last_load;
      logic          r_running;
      logic          r_overflow;
      logic          r_flag;
      logic [CW-1:0] w_start;
      logic          w_step;
      logic          w_edge;
      logic          w_wrap;

      assign w_start = bus.start_value[gi*CW +: CW];
      assign w_step  = bus.presc_en[gi] ? w_pwrap : w_tick;
      assign w_edge  = w_tick & bus.load[gi] & ~r_last_load;
      // A load edge reloads the counter, so it suppresses a coincident wrap.
      assign w_wrap  = r_running & bus.load[gi] & w_step & ~w_edge & (&r_cnt);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt       <= '0;
          r_last_load <= 1'b0;
          r_running   <= 1'b0;
          r_overflow  <= 1'b0;
          r_flag      <= 1'b0;
        end else begin
          if (w_tick) begin
            r_last_load <= bus.load[gi];
          end

          if (w_edge) begin
            r_cnt     <= w_start;
            r_running <= 1'b1;
          end else if (r_running && bus.load[gi] && w_step) begin
            if (&r_cnt) begin
              r_cnt <= w_start;
              if (bus.oneshot[gi]) begin
                r_running <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          r_overflow <= w_wrap;

          // Flag runs on every clock, independent of cen; clear wins over set.
          if (bus.clr_flag[gi]) begin
            r_flag <= 1'b0;
          end else if (r_overflow) begin
            r_flag <= 1'b1;
          end
        end
      end

      assign w_flag[gi]     = r_flag;
      assign w_overflow[gi] = r_overflow;
      assign w_running[gi]  = r_running;
    end
  endgenerate

  assign bus.flag     = w_flag;
  assign bus.overflow = w_overflow;
  assign bus.running  = w_running;
  assign bus.irq_n    = ~|(w_flag & bus.irq_en);

endmodule
`default_nettype wire

// File: doc/jt51_timer_bank.md
JT51_TIMER_BANK -- requirements
Module: jt51_timer_bank

Interface
REQ-001 Parameter N, default 2: number of independent timer channels, 1..8.
REQ-002 Parameter CW, default 10: counter width per channel, 4..16.
REQ-003 Parameter PW, default 4: shared prescaler width, 1..8.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 cen  in  1  clock enable.
REQ-007 zero  in  1  sample strobe; a tick is cen&&zero on a clk edge.
REQ-008 start_value  in  N*CW  per-channel reload value; channel i occupies bits [i*CW +: CW].
REQ-009 load  in  N  per-channel run request; rising edge starts the channel, level keeps it counting.
REQ-010 oneshot  in  N  per-channel mode: 0 auto-reload, 1 stop after first overflow.
REQ-011 presc_en  in  N  per-channel: 1 counts prescaler wraps, 0 counts every tick.
REQ-012 clr_flag  in  N  per-channel flag clear, level-sensitive.
REQ-013 irq_en  in  N  per-channel interrupt enable.
REQ-014 flag  out  N  per-channel sticky overflow flag.
REQ-015 overflow  out  N  per-channel one-clk overflow pulse.
REQ-016 running  out  N  channel armed and counting.
REQ-017 irq_n  out  1  active-low interrupt: ~|(flag & irq_en), combinational.

Function
REQ-018 Prescaler: PW-bit counter; +1 on every tick; wraps all-ones->0; p_wrap = tick with prescaler all-ones.
REQ-019 Per channel: step = presc_en ? p_wrap : tick.
REQ-020 last_load[i] updates to load[i] on ticks only; load edge = tick && load && !last_load.
REQ-021 Load edge: cnt <= start_value, running <= 1, takes priority over counting that tick.
REQ-022 running && load && step && not load edge: cnt <= cnt+1, CW-bit modulo.
REQ-023 Wrap = step with cnt all-ones while counting: cnt <= start_value; overflow[i] high for the next clk cycle only.
REQ-024 Wrap with oneshot=1: running <= 0; further counting needs a new load edge.
REQ-025 load low: cnt holds, running stays; reassertion gives a load edge and reloads.
REQ-026 Simultaneous load edge and all-ones cnt: reload wins; no overflow pulse.
REQ-027 flag updates every clk regardless of cen: clr_flag -> 0 (priority), else overflow -> 1, else hold.
REQ-028 start_value all-ones: overflow on every step (period 1 step).
REQ-029 Channels fully independent except shared prescaler and irq_n.
REQ-030 Parameter changes shall need no RTL edits; N=1 legal.

Reset
REQ-031 rst_n low asynchronously clears cnt, prescaler, last_load, running, flag, overflow to 0; irq_n = 1.
REQ-032 Reset mid-count aborts without overflow; after release a new load edge is required.

Verification (N=2, CW=10, PW=4, cen=zero=1 unless stated)
REQ-033 Ch0 auto-reload, start 0x3FC, load held high -> overflow[0] pulse every 4 clocks after load edge; flag[0]=1; irq_n=0 with irq_en[0]=1, 1 with irq_en[0]=0.
REQ-034 Ch1 oneshot, start 0x3FE -> one overflow[1] 2 ticks after load edge, then running[1]=0, no more pulses; load low->high repeats it once.
REQ-035 Ch0 presc_en=1, start 0x3FF, load high from reset release -> first overflow[0] at first prescaler wrap (tick 16); then every 16 ticks.
REQ-036 clr_flag[0] high in the overflow[0] cycle -> flag[0] stays 0; next overflow sets it.
REQ-037 load[0] dropped at cnt 0x3FD for 10 ticks -> cnt holds 0x3FD, no overflow; reassert -> cnt reloads start_value; zero=0 stalls counting entirely.
REQ-038 rst_n low mid-count, asynchronous to clk -> all outputs 0, irq_n=1 immediately; no overflow after release until new load edge.
